// File: rtl/regfile_writeback_arbiter.sv
// Sole register-file writer: merges MEM/WB pipeline results with buffered long-latency results.
// Latency: one cycle from acceptance to the registered RegWrite/WriteRegister/WriteData outputs.
// Backpressure: PipeStall holds MEM/WB when the FIFO is force-drained; LongReady deasserts when the FIFO is full.
module regfile_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     PipeRegWrite,
  input  logic [4:0]               PipeWriteRegister,
  input  logic [31:0]              PipeWriteData,
  output logic                     PipeStall,
  input  logic                     LongIssue,
  input  logic [4:0]               LongIssueReg,
  input  logic                     LongValid,
  input  logic [4:0]               LongReg,
  input  logic [31:0]              LongData,
  output logic                     LongReady,
  input  logic [4:0]               ReadRegister1,
  input  logic [4:0]               ReadRegister2,
  output logic                     Busy1,
  output logic                     Busy2,
  output logic                     RegWrite,
  output logic [4:0]               WriteRegister,
  output logic [31:0]              WriteData,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Long-result FIFO storage; contents need no reset because pointers/count define validity.
  logic [4:0]    fifo_reg_q [DEPTH];
  logic [31:0]   fifo_dat_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   pending_q, pending_d;

  // Registered write port, plus a flag saying the current write came from the FIFO.
  logic          rw_q, rw_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdat_q, wdat_d;
  logic          from_fifo_q, from_fifo_d;

  logic          fifo_nempty;
  logic          push;
  logic          pop;
  logic          force_pop;
  logic [4:0]    head_reg;
  logic [31:0]   head_dat;

  // Arbitration: a starved FIFO beats the pipeline, otherwise the pipeline has priority.
  always_comb begin
    fifo_nempty = (count_q != '0);
    LongReady   = (count_q < CW'(DEPTH));
    push        = LongValid && LongReady;
    force_pop   = (starve_q == SW'(STARVE_LIMIT)) && fifo_nempty;
    pop         = force_pop || (!PipeRegWrite && fifo_nempty);
    PipeStall   = force_pop && PipeRegWrite;
    head_reg    = fifo_reg_q[rd_ptr_q];
    head_dat    = fifo_dat_q[rd_ptr_q];
  end

  // Select the winner for the registered write port; writes to r0 are suppressed but still consume the slot.
  always_comb begin
    rw_d        = 1'b0;
    wreg_d      = wreg_q;
    wdat_d      = wdat_q;
    from_fifo_d = 1'b0;
    if (pop) begin
      rw_d        = (head_reg != 5'd0);
      wreg_d      = head_reg;
      wdat_d      = head_dat;
      from_fifo_d = 1'b1;
    end else if (PipeRegWrite) begin
      rw_d   = (PipeWriteRegister != 5'd0);
      wreg_d = PipeWriteRegister;
      wdat_d = PipeWriteData;
    end
  end

  // FIFO pointers, occupancy and starvation counter next state.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (fifo_nempty && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Pending scoreboard: retire clears the written bit, a new issue sets its bit and wins a tie.
  always_comb begin
    pending_d = pending_q;
    if (from_fifo_q) begin
      pending_d[wreg_q] = 1'b0;
    end
    if (LongIssue && (LongIssueReg != 5'd0)) begin
      pending_d[LongIssueReg] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      pending_q   <= '0;
      rw_q        <= 1'b0;
      wreg_q      <= 5'd0;
      wdat_q      <= 32'd0;
      from_fifo_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      pending_q   <= pending_d;
      rw_q        <= rw_d;
      wreg_q      <= wreg_d;
      wdat_q      <= wdat_d;
      from_fifo_q <= from_fifo_d;
    end
  end

  // FIFO tail write; suppressed during reset so nothing partial lands.
  always_ff @(posedge Clk) begin
    if (!Rst && push) begin
      fifo_reg_q[wr_ptr_q] <= LongReg;
      fifo_dat_q[wr_ptr_q] <= LongData;
    end
  end

  assign Busy1         = pending_q[ReadRegister1];
  assign Busy2         = pending_q[ReadRegister2];
  assign RegWrite      = rw_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdat_q;
  assign Count         = count_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed vector bench for regfile_writeback_arbiter.
// Each row drives one cycle, checks combinational outputs mid-cycle, registered outputs after the edge.
// Hand-written starvation sequence and full scoreboard sweep follow the table.
module tb_regfile_writeback_arbiter;

  logic        Clk;
  logic        Rst;
  logic        PipeRegWrite;
  logic [4:0]  PipeWriteRegister;
  logic [31:0] PipeWriteData;
  logic        PipeStall;
  logic        LongIssue;
  logic [4:0]  LongIssueReg;
  logic        LongValid;
  logic [4:0]  LongReg;
  logic [31:0] LongData;
  logic        LongReady;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        Busy1;
  logic        Busy2;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [2:0]  Count;

  int total = 0;
  int bad   = 0;

  regfile_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .Clk(Clk), .Rst(Rst),
    .PipeRegWrite(PipeRegWrite), .PipeWriteRegister(PipeWriteRegister),
    .PipeWriteData(PipeWriteData), .PipeStall(PipeStall),
    .LongIssue(LongIssue), .LongIssueReg(LongIssueReg),
    .LongValid(LongValid), .LongReg(LongReg), .LongData(LongData),
    .LongReady(LongReady),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Busy1(Busy1), .Busy2(Busy2),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        pw;
    logic [4:0]  preg;
    logic [31:0] pdat;
    logic        li;
    logic [4:0]  lir;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic        e_stall;
    logic        e_ready;
    logic        e_b1;
    logic        e_b2;
    logic        e_rw;
    logic        e_chk;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdat;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic pw, input logic [4:0] preg, input logic [31:0] pdat,
    input logic li, input logic [4:0] lir,
    input logic lv, input logic [4:0] lr, input logic [31:0] ld,
    input logic [4:0] rr1, input logic [4:0] rr2,
    input logic st, input logic rdy, input logic b1, input logic b2,
    input logic rw, input logic chk, input logic [4:0] wreg, input logic [31:0] wdat,
    input logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.pw = pw; v.preg = preg; v.pdat = pdat;
    v.li = li; v.lir = lir; v.lv = lv; v.lr = lr; v.ld = ld;
    v.rr1 = rr1; v.rr2 = rr2;
    v.e_stall = st; v.e_ready = rdy; v.e_b1 = b1; v.e_b2 = b2;
    v.e_rw = rw; v.e_chk = chk; v.e_wreg = wreg; v.e_wdat = wdat; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    PipeRegWrite = 1'b0; PipeWriteRegister = 5'd0; PipeWriteData = 32'd0;
    LongIssue = 1'b0; LongIssueReg = 5'd0;
    LongValid = 1'b0; LongReg = 5'd0; LongData = 32'd0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
  endtask

  initial begin
    int n;
    Rst = 1'b1;
    idle_inputs();

    // Basic pipe write
    vecs.push_back(mk(0,1,5,32'hAA,     0,0, 0,0,0,          0,0, 0,1,0,0, 1,1,5,32'hAA,0));
    // Long op to r8: scoreboard life cycle
    vecs.push_back(mk(0,0,0,0,          1,8, 0,0,0,          8,0, 0,1,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          8,0, 0,1,1,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          8,0, 0,1,1,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,          0,0, 1,8,32'h1234,   8,0, 0,1,1,0, 0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          8,0, 0,1,1,0, 1,1,8,32'h1234,0));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          8,0, 0,1,1,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          8,0, 0,1,0,0, 0,0,0,0,0));
    // Fill FIFO under continuous pipe traffic, forced drains
    vecs.push_back(mk(0,1,1,32'h101,    0,0, 1,10,32'hA0,    0,0, 0,1,0,0, 1,1,1,32'h101,1));
    vecs.push_back(mk(0,1,1,32'h102,    0,0, 1,11,32'hA1,    0,0, 0,1,0,0, 1,1,1,32'h102,2));
    vecs.push_back(mk(0,1,1,32'h103,    0,0, 1,12,32'hA2,    0,0, 0,1,0,0, 1,1,1,32'h103,3));
    vecs.push_back(mk(0,1,1,32'h104,    0,0, 1,13,32'hA3,    0,0, 0,1,0,0, 1,1,1,32'h104,4));
    vecs.push_back(mk(0,1,1,32'h105,    0,0, 1,14,32'hEE,    0,0, 1,0,0,0, 1,1,10,32'hA0,3));
    vecs.push_back(mk(0,1,1,32'h105,    0,0, 0,0,0,          0,0, 0,1,0,0, 1,1,1,32'h105,3));
    vecs.push_back(mk(0,1,1,32'h106,    0,0, 0,0,0,          0,0, 0,1,0,0, 1,1,1,32'h106,3));
    vecs.push_back(mk(0,1,1,32'h107,    0,0, 0,0,0,          0,0, 0,1,0,0, 1,1,1,32'h107,3));
    vecs.push_back(mk(0,1,1,32'h108,    0,0, 0,0,0,          0,0, 1,1,0,0, 1,1,11,32'hA1,2));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          0,0, 0,1,0,0, 1,1,12,32'hA2,1));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          0,0, 0,1,0,0, 1,1,13,32'hA3,0));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          0,0, 0,1,0,0, 0,0,0,0,0));
    // Register 0 from both sources
    vecs.push_back(mk(0,1,0,32'h55,     0,0, 0,0,0,          0,0, 0,1,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,          0,0, 1,0,32'h77,     0,0, 0,1,0,0, 0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          0,0, 0,1,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          0,0, 0,1,0,0, 0,0,0,0,0));
    // Simultaneous push and pop at Count=2, FIFO order
    vecs.push_back(mk(0,1,2,32'h900,    0,0, 1,20,32'h11,    0,0, 0,1,0,0, 1,1,2,32'h900,1));
    vecs.push_back(mk(0,1,2,32'h901,    0,0, 1,21,32'h22,    0,0, 0,1,0,0, 1,1,2,32'h901,2));
    vecs.push_back(mk(0,0,0,0,          0,0, 1,22,32'h33,    0,0, 0,1,0,0, 1,1,20,32'h11,2));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          0,0, 0,1,0,0, 1,1,21,32'h22,1));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          0,0, 0,1,0,0, 1,1,22,32'h33,0));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          0,0, 0,1,0,0, 0,0,0,0,0));
    // Mid-operation reset with Count=3 and r4, r9 pending
    vecs.push_back(mk(0,1,3,32'h300,    1,4, 1,15,32'hB0,    0,0, 0,1,0,0, 1,1,3,32'h300,1));
    vecs.push_back(mk(0,1,3,32'h301,    1,9, 1,16,32'hB1,    4,9, 0,1,1,0, 1,1,3,32'h301,2));
    vecs.push_back(mk(0,1,3,32'h302,    0,0, 1,17,32'hB2,    4,9, 0,1,1,1, 1,1,3,32'h302,3));
    vecs.push_back(mk(1,1,3,32'h303,    0,0, 1,18,32'hB3,    4,9, 0,1,1,1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,          0,0, 0,0,0,          4,9, 0,1,0,0, 0,0,0,0,0));

    // Initial reset
    repeat (2) @(posedge Clk);
    #1;
    chk("reset RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("reset WriteRegister", {27'd0, WriteRegister}, 32'd0);
    chk("reset WriteData", WriteData, 32'd0);
    chk("reset Count", {29'd0, Count}, 32'd0);
    chk("reset LongReady", {31'd0, LongReady}, 32'd1);

    foreach (vecs[i]) begin
      @(negedge Clk);
      Rst               = vecs[i].rst;
      PipeRegWrite      = vecs[i].pw;
      PipeWriteRegister = vecs[i].preg;
      PipeWriteData     = vecs[i].pdat;
      LongIssue         = vecs[i].li;
      LongIssueReg      = vecs[i].lir;
      LongValid         = vecs[i].lv;
      LongReg           = vecs[i].lr;
      LongData          = vecs[i].ld;
      ReadRegister1     = vecs[i].rr1;
      ReadRegister2     = vecs[i].rr2;
      #1;
      chk($sformatf("row%0d PipeStall", i), {31'd0, PipeStall}, {31'd0, vecs[i].e_stall});
      chk($sformatf("row%0d LongReady", i), {31'd0, LongReady}, {31'd0, vecs[i].e_ready});
      chk($sformatf("row%0d Busy1", i), {31'd0, Busy1}, {31'd0, vecs[i].e_b1});
      chk($sformatf("row%0d Busy2", i), {31'd0, Busy2}, {31'd0, vecs[i].e_b2});
      @(posedge Clk);
      #1;
      chk($sformatf("row%0d RegWrite", i), {31'd0, RegWrite}, {31'd0, vecs[i].e_rw});
      chk($sformatf("row%0d Count", i), {29'd0, Count}, {29'd0, vecs[i].e_cnt});
      if (vecs[i].e_chk) begin
        chk($sformatf("row%0d WriteRegister", i), {27'd0, WriteRegister}, {27'd0, vecs[i].e_wreg});
        chk($sformatf("row%0d WriteData", i), WriteData, vecs[i].e_wdat);
      end
    end

    // After the mid-operation reset no register may read busy
    @(negedge Clk);
    Rst = 1'b0;
    idle_inputs();
    for (int r = 0; r < 32; r++) begin
      ReadRegister1 = r[4:0];
      ReadRegister2 = 5'(31 - r);
      #1;
      chk($sformatf("sweep Busy1 r%0d", r), {31'd0, Busy1}, 32'd0);
      chk($sformatf("sweep Busy2 r%0d", r), {31'd0, Busy2}, 32'd0);
    end

    // Starvation: one FIFO entry behind constant pipe traffic is forced on the 4th cycle
    @(negedge Clk);
    PipeRegWrite = 1'b1; PipeWriteRegister = 5'd1; PipeWriteData = 32'h111;
    LongValid = 1'b1; LongReg = 5'd7; LongData = 32'h4242;
    @(posedge Clk);
    n = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge Clk);
      LongValid = 1'b0;
      #1;
      if (PipeStall) begin
        n = cyc;
        break;
      end
      @(posedge Clk);
    end
    chk("starve stall cycle", n, 32'd4);
    @(posedge Clk);
    #1;
    chk("starve RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("starve WriteRegister", {27'd0, WriteRegister}, 32'd7);
    chk("starve WriteData", WriteData, 32'h4242);
    chk("starve Count", {29'd0, Count}, 32'd0);
    @(negedge Clk);
    #1;
    chk("starve stall released", {31'd0, PipeStall}, 32'd0);
    @(posedge Clk);
    #1;
    chk("starve pipe resumes", WriteData, 32'h111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Sole writer of the 32x32 register file write port (RegWrite / WriteRegister / WriteData).
- Merges two result sources:
  - the in-order pipeline writeback (MEM/WB), which has priority;
  - a long-latency unit (multiply/divide), buffered in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on results still in flight from the long-latency unit.

Parameters:
- DEPTH, 4, long-result FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO may lose arbitration before it is forced through

Ports:
- Clk  in  1  clock; all state updates on posedge
- Rst  in  1  synchronous, active-high reset
- PipeRegWrite  in  1  pipeline result valid this cycle
- PipeWriteRegister  in  5  pipeline destination register
- PipeWriteData  in  32  pipeline result
- PipeStall  out  1  pipeline write not accepted this cycle; upstream holds MEM/WB
- LongIssue  in  1  long op issued this cycle; marks destination pending
- LongIssueReg  in  5  destination of issued long op
- LongValid  in  1  long result offered
- LongReg  in  5  long result destination
- LongData  in  32  long result data
- LongReady  out  1  FIFO can accept a result
- ReadRegister1  in  5  decode source register 1, for the scoreboard query
- ReadRegister2  in  5  decode source register 2, for the scoreboard query
- Busy1  out  1  ReadRegister1 has a pending long result
- Busy2  out  1  ReadRegister2 has a pending long result
- RegWrite  out  1  register file write enable, registered
- WriteRegister  out  5  register file write address, registered
- WriteData  out  32  register file write data, registered
- Count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (Rst=1 at posedge, takes priority over all other events):
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - FIFO emptied; Count=0; read/write pointers=0.
  - Pending scoreboard = 32'b0; starvation counter=0.
  - Any in-flight FIFO contents are discarded.
- LongReady = (Count < DEPTH), combinational. Pushes happen only when the FIFO has room, so a pop never frees space for a same-cycle push.
- Push: when LongValid && LongReady, write {LongReg, LongData} at the tail on posedge. LongValid while LongReady=0 is ignored; the source must hold its result.
- Arbitration is evaluated combinationally each cycle, and the winner is registered onto the outputs at posedge:
  - Force = (starve_cnt == STARVE_LIMIT) && Count != 0.
  - If Force: pop the FIFO head and assert PipeStall = PipeRegWrite.
  - Else if PipeRegWrite: take the pipeline write; PipeStall=0.
  - Else if Count != 0: pop the FIFO head.
  - Else: RegWrite=0 next cycle.
- Latency: a write accepted at posedge k appears on the outputs after k; the register file commits it at posedge k+1.
- Register 0:
  - Any selected write (pipe or FIFO) to register 0 drives RegWrite=0.
  - A FIFO entry to register 0 is still popped and still consumes the arbitration slot.
- starve_cnt:
  - cleared on reset and on any pop;
  - increments (saturating at STARVE_LIMIT) when Count != 0 and no pop occurs;
  - holds when Count == 0.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop. Pointers wrap modulo DEPTH.
- Pending scoreboard:
  - Set bit LongIssueReg when LongIssue is asserted and LongIssueReg != 0.
  - Clear bit WriteRegister on the posedge when the registered outputs carry a FIFO-sourced write.
  - Same bit set and cleared in one cycle: set wins.
  - Bit 0 is always 0.
  - Decode must not issue a second long op to a busy register; with a single bit per register, the first retire clears it.
- Busy1 = pending[ReadRegister1], Busy2 = pending[ReadRegister2]; combinational, with no same-cycle bypass from set/clear.
- Reset asserted mid-operation discards all state, with no partial writes.

Test Plan:
- Reset, then a pipe write of r5=0x0000_00AA at cycle 1 -> RegWrite=1, WriteRegister=5, WriteData=0xAA after the next edge; Count=0; PipeStall=0.
- LongIssue r8, then 3 cycles later LongValid r8=0x1234 with no pipe traffic -> Busy1(Read=8) is 1 from the cycle after issue until the cycle after the write; write r8=0x1234 appears one cycle after the push.
- Push 4 long results with the pipe idle-blocked (PipeRegWrite=1 to r1 every cycle) -> Count=4 and LongReady=0; after 3 lost cycles the FIFO is forced (PipeStall=1 for exactly one cycle) and the head entry is written; Count=3.
- Pipe write to r0 and a FIFO entry to r0 -> RegWrite stays 0; the FIFO entry is still popped and Count decrements.
- Simultaneous push and pop at Count=2 -> Count stays 2 and entries drain in FIFO order (data 0x11, 0x22, 0x33 written in sequence).
- Rst asserted with Count=3 and pending r4,r9 set -> the next cycle has Count=0, Busy=0 for all registers, RegWrite=0, LongReady=1.
